mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h01000000, base byte address of the memory.
REQ-002 SHALL have parameter MEM_SIZE, default 32'h100000, memory size in bytes.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst_n` (in, 1): one clock; reset is asynchronous and active-low.
REQ-004 SHALL have the fetch port: if_req_valid in 1; if_req_ready out 1; if_addr in 32; if_rsp_valid out 1; if_rsp_data out 32; if_rsp_err out 1.
REQ-005 SHALL have the data request port: d_req_valid in 1; d_req_ready out 1; d_addr in 32; d_wdata in 32; d_we in 1; d_size in 2 (BYTE/HALFWORD/WORD); d_rdun in 1 (unsigned load).
REQ-006 SHALL have the data response port: d_rsp_valid out 1; d_rsp_data out 32; d_rsp_err out 1.
REQ-007 SHALL have the memory port: mem_addr out 32; mem_wdata out 32; mem_we out 1; mem_size out 2; mem_rdun out 1; mem_rdata in 32 (combinational read, write committed on posedge).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-009 SHALL assert if_req_ready and d_req_ready only in IDLE or RESP, and only for the requester granted that cycle.
REQ-010 SHALL accept a request on a posedge where valid && ready, latch it, and enter ACCESS.
REQ-011 SHALL, without the round-robin macro, grant data over fetch when both are valid; the losing requester holds its request.
REQ-012 SHALL, in ACCESS, drive mem_* from the latched request; fetch forces mem_size=WORD, mem_rdun=0 and mem_we=0.
REQ-013 SHALL capture mem_rdata at the end of ACCESS and go to RESP.
REQ-014 SHALL assert the owning rsp_valid for exactly one cycle in RESP, with data and err stable during that cycle; there is no response backpressure.
REQ-015 SHALL, in RESP, go to ACCESS if a new request is accepted, else to IDLE; throughput is 1 access per 2 cycles and latency is accept edge N to rsp_valid during cycle N+2.
REQ-016 SHALL flag an error for: size 2'b11; a HALFWORD address not 2-aligned; a WORD address not 4-aligned; any byte of the access outside [START_ADDR, START_ADDR+MEM_SIZE-1].
REQ-017 SHALL, on error, hold mem_we at 0 and return rsp_err=1 with rsp_data=32'hBADB_ADFF.
REQ-018 SHALL drive mem_we high only in ACCESS, for a latched write with no error.
REQ-019 SHALL compute range checks in 33 bits so that an address near 32'hFFFFFFFF cannot wrap into range.
REQ-020 SHALL hold mem_* at the last latched values outside ACCESS, with mem_we=0.

Reset
REQ-021 SHALL, on rst_n low, immediately force state=IDLE, mem_we=0, all rsp_valid=0, all rsp_data=0, all rsp_err=0 and the ready outputs to 0.
REQ-022 SHALL drop the in-flight access when reset is asserted during ACCESS: no write is committed and no response is issued.
REQ-023 SHALL resume arbitration on the first posedge after rst_n deasserts.

Configuration
REQ-024 SHALL, with MEM_ARB_RR_EN defined, use round-robin arbitration: on contention, grant the requester not granted last; the pointer resets to "fetch last" so data wins first.
REQ-025 SHALL, without MEM_ARB_RR_EN, use fixed data>fetch priority and contain no pointer register.

Structure
REQ-026 SHALL place these items in package mem_arb_pkg: size encodings (BYTE=0, HALFWORD=1, WORD=2), the FSM state enum, the 32'hBADB_ADFF error constant, and the default START_ADDR/MEM_SIZE.
REQ-027 SHALL implement alignment and range checking in one combinational sub-module, mem_access_check, instantiated once on the latched request.

Verification
REQ-028 SHALL cover: fetch only, if_addr=32'h01000000, mem_rdata=32'h00500093 -> if_rsp_valid in cycle N+2 with if_rsp_data=32'h00500093 and if_rsp_err=0.
REQ-029 SHALL cover: simultaneous fetch 32'h01000004 and data read 32'h01000100 -> data served first, fetch second; with MEM_ARB_RR_EN, a repeated tie alternates grants.
REQ-030 SHALL cover: data write WORD to 32'h01000102 -> d_rsp_err=1, d_rsp_data=32'hBADB_ADFF, mem_we never high.
REQ-031 SHALL cover: data read BYTE at 32'h01100000 (one past end) -> err=1; BYTE at 32'h010FFFFF -> err=0.
REQ-032 SHALL cover: back-to-back data writes -> mem_we high in alternating cycles, with each d_rsp_valid one cycle wide.
REQ-033 SHALL cover: rst_n pulled low mid-ACCESS on a write -> mem_we drops immediately, no rsp_valid, state IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Size encodings, FSM state enum, error return word, default memory window.
// No logic; imported by mem_access_check and mem_arbiter.
package mem_arb_pkg;

  localparam logic [1:0] BYTE     = 2'd0;
  localparam logic [1:0] HALFWORD = 2'd1;
  localparam logic [1:0] WORD     = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA       = 32'hBADB_ADFF;
  localparam logic [31:0] DEF_START_ADDR = 32'h0100_0000;
  localparam logic [31:0] DEF_MEM_SIZE   = 32'h0010_0000;

endpackage

// File: rtl/mem_access_check.sv
// Alignment / size / range legality check for one memory access.
// Purely combinational, zero latency.
// No handshake; evaluated continuously on the latched request.
module mem_access_check
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEF_START_ADDR,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic        o_err
);

  logic [32:0] w_span;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  logic [32:0] w_base;
  logic [32:0] w_last;
  logic        w_size_bad;
  logic        w_misalign;
  logic        w_out_of_range;

  // Offset of the last byte touched; 33-bit so high addresses cannot wrap.
  always_comb begin
    w_span = 33'd0;
    case (i_size)
      HALFWORD: w_span = 33'd1;
      WORD:     w_span = 33'd3;
      default:  w_span = 33'd0;
    endcase
  end

  assign w_lo           = {1'b0, i_addr};
  assign w_hi           = w_lo + w_span;
  assign w_base         = {1'b0, START_ADDR};
  assign w_last         = w_base + {1'b0, MEM_SIZE} - 33'd1;
  assign w_size_bad     = (i_size == 2'b11);
  assign w_misalign     = ((i_size == HALFWORD) && i_addr[0]) ||
                          ((i_size == WORD) && (i_addr[1:0] != 2'b00));
  assign w_out_of_range = (w_lo < w_base) || (w_hi > w_last);
  assign o_err          = w_size_bad || w_misalign || w_out_of_range;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data requests onto one memory port.
// Latency: accept edge -> one ACCESS cycle -> response valid for one cycle; 1 access / 2 cycles.
// Requesters are held off via ready (only in IDLE/RESP); responses cannot be backpressured.
// Optional: define MEM_ARB_RR_EN for round-robin instead of fixed data>fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEF_START_ADDR,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_rdun,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_rdun,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_is_d;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_rdun;
  logic        r_if_rsp_vld;
  logic [31:0] r_if_rsp_dat;
  logic        r_if_rsp_err;
  logic        r_d_rsp_vld;
  logic [31:0] r_d_rsp_dat;
  logic        r_d_rsp_err;
  logic        w_pick_d;
  logic        w_pick_if;
  logic        w_open;
  logic        w_accept;
  logic        w_err;

  // Ready is only offered while reset is released and the FSM can take a request.
  assign w_open = rst_n && ((r_state == IDLE) || (r_state == RESP));

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // On contention grant whoever was not served last; otherwise whoever asks.
  always_comb begin
    w_pick_d  = d_req_valid && (!if_req_valid || !r_last_d);
    w_pick_if = if_req_valid && !w_pick_d;
  end

  // Remember who won the last accepted request; resets to "fetch last".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_accept) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  always_comb begin
    w_pick_d  = d_req_valid;
    w_pick_if = if_req_valid && !d_req_valid;
  end
`endif

  mem_access_check #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE)
  ) u_check (
    .i_addr (r_addr),
    .i_size (r_size),
    .o_err  (w_err)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake readies and write strobe.
  always_comb begin
    w_state_nxt  = r_state;
    d_req_ready  = w_open && w_pick_d;
    if_req_ready = w_open && w_pick_if;
    w_accept     = d_req_ready || if_req_ready;
    mem_we       = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ACCESS;
      ACCESS: begin
        w_state_nxt = RESP;
        mem_we      = r_we && !w_err;
      end
      RESP:    w_state_nxt = w_accept ? ACCESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the accepted request; fetches are forced to plain word reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_d  <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_size  <= WORD;
      r_rdun  <= 1'b0;
    end else if (w_accept) begin
      r_is_d <= w_pick_d;
      r_addr <= w_pick_d ? d_addr : if_addr;
      r_we   <= w_pick_d && d_we;
      r_size <= w_pick_d ? d_size : WORD;
      r_rdun <= w_pick_d && d_rdun;
      if (w_pick_d) r_wdata <= d_wdata;
    end
  end

  // Capture read data (or the error word) at the end of ACCESS for a one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_vld <= 1'b0;
      r_if_rsp_dat <= 32'd0;
      r_if_rsp_err <= 1'b0;
      r_d_rsp_vld  <= 1'b0;
      r_d_rsp_dat  <= 32'd0;
      r_d_rsp_err  <= 1'b0;
    end else begin
      r_if_rsp_vld <= 1'b0;
      r_d_rsp_vld  <= 1'b0;
      if (r_state == ACCESS) begin
        if (r_is_d) begin
          r_d_rsp_vld <= 1'b1;
          r_d_rsp_dat <= w_err ? ERR_DATA : mem_rdata;
          r_d_rsp_err <= w_err;
        end else begin
          r_if_rsp_vld <= 1'b1;
          r_if_rsp_dat <= w_err ? ERR_DATA : mem_rdata;
          r_if_rsp_err <= w_err;
        end
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign mem_size     = r_size;
  assign mem_rdun     = r_rdun;
  assign if_rsp_valid = r_if_rsp_vld;
  assign if_rsp_data  = r_if_rsp_dat;
  assign if_rsp_err   = r_if_rsp_err;
  assign d_rsp_valid  = r_d_rsp_vld;
  assign d_rsp_data   = r_d_rsp_dat;
  assign d_rsp_err    = r_d_rsp_err;

endmodule
